// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller between a host req/done four-phase handshake
// and a single-cycle core. On request it picks one of four entry points. It
// holds the core in reset for RST_CYC cycles and then strobes a PC load. It
// lets the core run until halt while counting run cycles, and reports done.
// Optional watchdog: define WATCHDOG_EN to abort runs that reach TMO cycles.
module prog_sequencer #(
  parameter int unsigned    D       = 12,
  parameter int unsigned    CW      = 16,
  parameter int unsigned    RST_CYC = 2,
  parameter logic [D-1:0]   E0      = '0,
  parameter logic [D-1:0]   E1      = '0,
  parameter logic [D-1:0]   E2      = '0,
  parameter logic [D-1:0]   E3      = '0,
  parameter int unsigned    TMO     = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [1:0]    prog_sel,
  input  logic          core_halt,
  output logic          core_rst,
  output logic          start_en,
  output logic [D-1:0]  start_addr,
  output logic          run,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
  localparam logic [CW-1:0]  CYC_MAX  = {CW{1'b1}};

`ifdef WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [D-1:0]    addr_q, addr_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic            timeout_q, timeout_d;
  logic            core_rst_q, core_rst_d;
  logic            start_en_q, start_en_d;
  logic            run_q, run_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [D-1:0]    entry_c;
  logic            wd_hit_c;

  // Entry address selected by the program select input
  always_comb begin
    entry_c = E0;
    case (prog_sel)
      2'd0:    entry_c = E0;
      2'd1:    entry_c = E1;
      2'd2:    entry_c = E2;
      default: entry_c = E3;
    endcase
  end

  // Watchdog limit: the current RUN increment would make cycles reach TMO
  always_comb begin
    wd_hit_c = WD_EN && (32'(cycles_q) == (TMO - 32'd1));
  end

  // Next-state logic and registered-output decode of the state being entered
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    addr_d     = addr_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    core_rst_d = 1'b1;
    start_en_d = 1'b0;
    run_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d    = entry_c;
          timeout_d = 1'b0;
          rst_cnt_d = '0;
          state_d   = S_RST;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          cycles_d = '0;
          state_d  = S_START;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (core_halt) begin
          state_d = S_DONE;
        end else begin
          if (cycles_q != CYC_MAX) begin
            cycles_d = cycles_q + CW'(1);
          end
          if (wd_hit_c) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_RST: begin
        busy_d = 1'b1;
      end
      S_START: begin
        core_rst_d = 1'b0;
        start_en_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_RUN: begin
        core_rst_d = 1'b0;
        run_d      = 1'b1;
        busy_d     = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        core_rst_d = 1'b1;
      end
    endcase
  end

  // State, counters and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rst_cnt_q  <= '0;
      addr_q     <= '0;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
      start_en_q <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      addr_q     <= addr_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
      core_rst_q <= core_rst_d;
      start_en_q <= start_en_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign core_rst   = core_rst_q;
  assign start_en   = start_en_q;
  assign start_addr = addr_q;
  assign run        = run_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run controller between the testbench/host `req`/`done` handshake and the single-cycle core.
- On request: selects one of four program entry points, holds the core in reset, then loads the PC with the entry address.
- Lets the core run until it signals halt and counts the run cycles.
- Returns `done` with a four-phase handshake; optional watchdog aborts runaway programs.

Parameters:
- D, 12, program counter / start address width (matches core PC).
- CW, 16, cycle counter width.
- RST_CYC, 2, cycles core_rst is held before the PC load (>=1).
- E0, 12'h000, entry address for prog_sel=0.
- E1, 12'h000, entry address for prog_sel=1.
- E2, 12'h000, entry address for prog_sel=2.
- E3, 12'h000, entry address for prog_sel=3.
- TMO, 4095, watchdog limit in run cycles (used only with WATCHDOG_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  host run request, level, four-phase.
- prog_sel  in  2  program select, sampled on request accept.
- core_halt  in  1  core reached halt (e.g. prog_ctr at halt address).
- core_rst  out  1  active-high hold/reset to the core.
- start_en  out  1  one-cycle PC absolute-load strobe.
- start_addr  out  D  entry address for PC load.
- run  out  1  core is executing.
- busy  out  1  sequencer is in RST, START or RUN.
- done  out  1  run complete (level).
- timeout  out  1  run ended by watchdog.
- cycles  out  CW  run cycle count of the current or last run.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge), from any state including mid-run:
  - state=IDLE, core_rst=1, start_en=0, start_addr=0, run=0, busy=0, done=0, timeout=0, cycles=0.
- States: IDLE, RST, START, RUN, DONE.
- IDLE:
  - core_rst=1.
  - req=1 accepts the request: latch start_addr from E[prog_sel], clear timeout, go to RST.
  - cycles keeps the last value until START.
- RST:
  - core_rst=1, busy=1.
  - Internal counter runs RST_CYC cycles, then go to START.
- START (exactly 1 cycle):
  - core_rst=0, start_en=1, busy=1, cycles cleared to 0, go to RUN.
- RUN:
  - core_rst=0, run=1, busy=1.
  - core_halt=1: go to DONE; this cycle is not counted.
  - core_halt=0: cycles increments, saturating at 2^CW-1 (no wrap).
- DONE:
  - core_rst=1 (freezes core), done=1; cycles and timeout are held.
  - Stay in DONE while req=1.
  - req=0: go to IDLE; done drops the next cycle.
- Latency: req accepted at edge T.
  - RST covers T+1..T+RST_CYC.
  - start_en at T+RST_CYC+1.
  - run first high at T+RST_CYC+2.
- req is ignored in RST, START and RUN. Deasserting req mid-run does not abort the run; done is then high for exactly 1 cycle.
- A new request is only accepted in IDLE. req held high continuously yields exactly one run.
- prog_sel changes after accept have no effect.
- core_halt outside RUN is ignored.
- Core halt on the first RUN cycle: cycles=0, done asserted.

Optional Feature:
- Macro WATCHDOG_EN.
- Defined:
  - In RUN with core_halt=0 and cycles==TMO-1, the increment makes cycles=TMO; go to DONE with timeout=1.
  - If core_halt=1 and the limit condition occur in the same cycle, halt wins and timeout=0.
- Undefined:
  - No watchdog; timeout is tied to 0 and RUN lasts until core_halt.
  - cycles saturates.

Test Plan (RST_CYC=2, E1=12'h040, TMO=100):
- Reset held low 3 cycles while the FSM is in RUN -> after the edge: core_rst=1, run=0, busy=0, done=0, cycles=0, state IDLE.
- req=1, prog_sel=1 at edge T; core_halt raised 10 cycles after run rises:
  - start_en=1 only at T+3 with start_addr=12'h040; run=1 from T+4.
  - done=1, cycles=10, timeout=0.
  - After req=0: done=0 one cycle later.
- Back-to-back with req held high throughout -> exactly one start_en pulse, done stays 1. req low then high -> second run starts, cycles cleared at its START.
- req dropped during RUN and prog_sel toggled -> run unaffected; done high for exactly 1 cycle, then IDLE.
- WATCHDOG_EN, core_halt never asserted -> DONE after 100 RUN cycles, cycles=100, timeout=1. Halt at the limit cycle -> timeout=0.
- Without WATCHDOG_EN, CW=4, halt after 20 cycles -> cycles=15 (saturated), timeout=0.
